// File: rtl/ex_mdu.sv
// RV32M execute-stage multiply/divide unit: iterative shift-add multiply, restoring divide.
// Define MDU_FAST_MUL_EN to compute MUL* in a single cycle; the divide path is unchanged.
module ex_mdu #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        stall_sign,
  input  logic [6:0]        ex_opcode,
  input  logic [2:0]        ex_funct3,
  input  logic [6:0]        ex_funct7,
  input  logic [XLEN-1:0]   ex_reg1,
  input  logic [XLEN-1:0]   ex_reg2,
  input  logic [4:0]        ex_wd,
  input  logic              ex_wreg,
  output logic              mdu_stallreq,
  output logic              mdu_done,
  output logic [XLEN-1:0]   mdu_result,
  output logic [4:0]        mdu_wd,
  output logic              mdu_wreg
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t            r_state, w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [XLEN-1:0]   r_a, r_b, r_hi, r_lo;
  logic              r_s1, r_s2;
  logic [2:0]        r_f3;
  logic [4:0]        r_wd_l;
  logic              r_wreg_l;
  logic [XLEN-1:0]   r_result;
  logic [4:0]        r_wd;
  logic              r_wreg;

  logic              w_mop, w_uns1, w_uns2, w_s1, w_s2, w_divz, w_ovf, w_last;
  logic [XLEN-1:0]   w_mag1, w_mag2, w_spec_res;
  logic [XLEN:0]     w_mul_sum;
  logic [2*XLEN-1:0] w_mul_next, w_prod;
  logic [XLEN-1:0]   w_mul_res;
  logic [XLEN:0]     w_div_sh, w_div_diff, w_div_rem;
  logic              w_div_ge;
  logic [XLEN-1:0]   w_div_quo, w_quo_s, w_rem_s, w_div_res;
  logic              w_unused;

  assign w_mop  = (ex_opcode == 7'b0110011) && (ex_funct7 == 7'b0000001);
  assign w_uns1 = (ex_funct3 == 3'b011) || (ex_funct3 == 3'b101) || (ex_funct3 == 3'b111);
  assign w_uns2 = w_uns1 || (ex_funct3 == 3'b010);
  assign w_s1   = !w_uns1 && ex_reg1[XLEN-1];
  assign w_s2   = !w_uns2 && ex_reg2[XLEN-1];
  assign w_mag1 = w_s1 ? -ex_reg1 : ex_reg1;
  assign w_mag2 = w_s2 ? -ex_reg2 : ex_reg2;
  assign w_divz = ex_funct3[2] && (ex_reg2 == '0);
  assign w_ovf  = ex_funct3[2] && !ex_funct3[0] &&
                  (ex_reg1 == {1'b1, {(XLEN-1){1'b0}}}) && (ex_reg2 == '1);
  // Divide-by-zero wins over overflow; remainder ops take the second choice.
  assign w_spec_res = w_divz ? (ex_funct3[1] ? ex_reg1 : '1)
                             : (ex_funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}});
  assign w_last = (r_cnt == CNT_W'(XLEN-1));

  // Multiplier sits in r_lo and shifts out as the product shifts in from r_hi.
  assign w_mul_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : '0);
  assign w_mul_next = {w_mul_sum, r_lo[XLEN-1:1]};
  assign w_prod     = (r_s1 ^ r_s2) ? -w_mul_next : w_mul_next;
  assign w_mul_res  = (r_f3[1:0] == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];

  assign w_div_sh   = {r_hi, r_lo[XLEN-1]};
  assign w_div_diff = w_div_sh - {1'b0, r_b};
  assign w_div_ge   = (w_div_sh >= {1'b0, r_b});
  assign w_div_rem  = w_div_ge ? w_div_diff : w_div_sh;
  assign w_div_quo  = {r_lo[XLEN-2:0], w_div_ge};
  assign w_quo_s    = (r_s1 ^ r_s2) ? -w_div_quo : w_div_quo;
  assign w_rem_s    = r_s1 ? -w_div_rem[XLEN-1:0] : w_div_rem[XLEN-1:0];
  assign w_div_res  = r_f3[1] ? w_rem_s : w_quo_s;

`ifdef MDU_FAST_MUL_EN
  logic signed [2*XLEN+1:0] w_fast_prod;
  logic [XLEN-1:0]          w_fast_res;
  assign w_fast_prod = $signed({w_s1 | (!w_uns1 && ex_reg1[XLEN-1]), ex_reg1}) *
                       $signed({!w_uns2 && ex_reg2[XLEN-1], ex_reg2});
  assign w_fast_res  = (ex_funct3[1:0] == 2'b00) ? w_fast_prod[XLEN-1:0]
                                                 : w_fast_prod[2*XLEN-1:XLEN];
  assign w_unused    = ^{stall_sign[5:4], stall_sign[2:0], w_fast_prod[2*XLEN+1:2*XLEN]};
`else
  assign w_unused    = ^{stall_sign[5:4], stall_sign[2:0]};
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_mop) begin
          if (w_divz || w_ovf)   w_next = S_DONE;
          else if (ex_funct3[2]) w_next = S_DIV;
`ifdef MDU_FAST_MUL_EN
          else                   w_next = S_DONE;
`else
          else                   w_next = S_MUL;
`endif
        end
      end
      S_MUL:   if (w_last) w_next = S_DONE;
      S_DIV:   if (w_last) w_next = S_DONE;
      S_DONE:  if (!stall_sign[3]) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_s1     <= 1'b0;
      r_s2     <= 1'b0;
      r_f3     <= '0;
      r_wd_l   <= '0;
      r_wreg_l <= 1'b0;
      r_result <= '0;
      r_wd     <= '0;
      r_wreg   <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: if (w_mop) begin
          r_a      <= w_mag1;
          r_b      <= w_mag2;
          r_s1     <= w_s1;
          r_s2     <= w_s2;
          r_f3     <= ex_funct3;
          r_wd_l   <= ex_wd;
          r_wreg_l <= ex_wreg;
          r_cnt    <= '0;
          r_hi     <= '0;
          r_lo     <= ex_funct3[2] ? w_mag1 : w_mag2;
          if (w_divz || w_ovf) begin
            r_result <= w_spec_res;
            r_wd     <= ex_wd;
            r_wreg   <= ex_wreg;
          end
`ifdef MDU_FAST_MUL_EN
          else if (!ex_funct3[2]) begin
            r_result <= w_fast_res;
            r_wd     <= ex_wd;
            r_wreg   <= ex_wreg;
          end
`endif
        end
        S_MUL: begin
          {r_hi, r_lo} <= w_mul_next;
          r_cnt        <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_result <= w_mul_res;
            r_wd     <= r_wd_l;
            r_wreg   <= r_wreg_l;
          end
        end
        S_DIV: begin
          r_hi  <= w_div_rem[XLEN-1:0];
          r_lo  <= w_div_quo;
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_result <= w_div_res;
            r_wd     <= r_wd_l;
            r_wreg   <= r_wreg_l;
          end
        end
        default: ;
      endcase
    end
  end

  assign mdu_stallreq = !rst && (((r_state == S_IDLE) && w_mop) ||
                                 (r_state == S_MUL) || (r_state == S_DIV));
  assign mdu_done     = (r_state == S_DONE);
  assign mdu_result   = r_result;
  assign mdu_wd       = r_wd;
  assign mdu_wreg     = r_wreg;

endmodule

// File: doc/ex_mdu.md
Name: ex_mdu

Overview:
- Execute-stage multiply/divide unit for the RV32M extension.
- Consumes the registered EX operands and control produced by the ID/EX pipeline register.
- Performs iterative multiply and divide, and raises a stall request to the pipeline controller while busy.
- Presents the result, destination register and write enable to the EX/MEM path when done.

Parameters:
- XLEN, 32, operand/result width (only 32 supported)
- CNT_W, 6, iteration counter width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- stall_sign  in  6  controller stall vector; bit 3 = ID/EX hold, bit 4 = EX/MEM hold
- ex_opcode  in  7  instruction opcode from ID/EX
- ex_funct3  in  3  funct3 from ID/EX
- ex_funct7  in  7  funct7 from ID/EX
- ex_reg1  in  32  rs1 operand
- ex_reg2  in  32  rs2 operand
- ex_wd  in  5  destination register address
- ex_wreg  in  1  write enable of current instruction
- mdu_stallreq  out  1  stall request to controller (combinational)
- mdu_done  out  1  result valid (registered state)
- mdu_result  out  32  result value
- mdu_wd  out  5  destination register for result
- mdu_wreg  out  1  write enable for result

Behaviour:
- Interface: reset rst, synchronous, active-high; clock clk.
- M-op detect: ex_opcode==7'b0110011 and ex_funct7==7'b0000001.
- funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- Reset (rst high at posedge): state=IDLE; mdu_done=0, mdu_result=0, mdu_wd=0, mdu_wreg=0, counter=0. mdu_stallreq=0 while rst high. Reset mid-operation aborts with no result.
- States: IDLE, MUL, DIV, DONE.
- mdu_stallreq = (IDLE and M-op) or MUL or DIV; 0 in DONE.
- IDLE, M-op present: latch operand magnitudes, sign flags, funct3, ex_wd, ex_wreg; counter=0.
  - Divide by zero: quotient=32'hFFFFFFFF, remainder=rs1. Go directly to DONE.
  - Signed overflow (DIV/REM, rs1=32'h80000000, rs2=32'hFFFFFFFF): quotient=32'h80000000, remainder=0. Go directly to DONE.
  - Otherwise go to MUL (funct3[2]=0) or DIV (funct3[2]=1).
- Signedness:
  - MUL, MULH, DIV, REM: both operands signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - MULHU, DIVU, REMU: both unsigned.
  - Magnitudes are used internally; signs are applied at finish.
- MUL state: radix-2 shift-add of 32x32 magnitudes into a 64-bit accumulator, one bit per cycle, 32 cycles.
  - Last cycle: negate the 64-bit product if the signs differ.
  - Select low word (MUL) or high word (MULH*) into mdu_result; state=DONE.
- DIV state: restoring division, one quotient bit per cycle, 32 cycles.
  - Last cycle: quotient sign = sign1 xor sign2; remainder sign = sign1.
  - Select quotient (DIV/DIVU) or remainder (REM/REMU); state=DONE.
- Latency: op seen at cycle 0; stallreq high cycles 0..32; DONE (mdu_done=1) from cycle 33. Special cases: DONE at cycle 1.
- DONE: mdu_done=1; mdu_result, mdu_wd, mdu_wreg held stable.
  - Posedge with stall_sign[3]==0: ID/EX loads next instruction; state=IDLE, mdu_done=0.
  - stall_sign[3]==1 (downstream stall): hold DONE. Never restart on the same instruction.
- Non-M op in IDLE: outputs unchanged, mdu_done=0, no stall.
- ex_wreg==0 with an M-op: still executes; mdu_wreg=0.

Optional Feature:
- Macro: MDU_FAST_MUL_EN.
- Defined: MUL* computed by a single-cycle 33x33 signed product in IDLE; state goes IDLE->DONE; stallreq high only in cycle 0; mdu_done at cycle 1. Divide path unchanged.
- Undefined: iterative 32-cycle multiplier as above.

Test Plan:
- MUL rs1=7, rs2=-3 (32'hFFFFFFFD) -> mdu_result=32'hFFFFFFEB; stallreq high 33 cycles (1 with MDU_FAST_MUL_EN); mdu_done, mdu_wd match ex_wd.
- MULHU rs1=rs2=32'hFFFFFFFF -> 32'hFFFFFFFE. MULH same operands -> 0. MULHSU rs1=-1, rs2=2 -> 32'hFFFFFFFF.
- DIV -7/2 -> 32'hFFFFFFFD; REM -7/2 -> 32'hFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2; each with done at cycle 33.
- DIV x/0 -> 32'hFFFFFFFF, REM x/0 -> x. DIV 32'h80000000/-1 -> 32'h80000000, REM -> 0. All done at cycle 1.
- DONE with stall_sign[3:4]=2'b11 for 5 cycles -> result held, no restart, stallreq=0; release -> IDLE, next op accepted.
- rst asserted at iteration 10 of DIV -> all outputs 0, IDLE next cycle; fresh DIVU 9/3 afterward -> 3.
